// File: rtl/ysyx_23060077_wb_ctrl_if.sv
// ysyx_23060077_wb_ctrl_if: EXU/LSU/register-file bundle of the writeback sequencer.
interface ysyx_23060077_wb_ctrl_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int LSU_OPT_WIDTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LSU_OPT_WIDTH-1:0]  in_lsu_opt;
   logic [DATA_WIDTH-1:0]     in_exu_result;
   logic [DATA_WIDTH-1:0]     in_csr_result;
   logic [REG_ADDR_WIDTH-1:0] in_rd;
   logic                      in_rd_wen;
   logic [DATA_WIDTH-1:0]     in_pc;
   logic                      lsu_rsp_valid;
   logic [DATA_WIDTH-1:0]     lsu_rdata;
   logic                      rf_wen;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0]     rf_wdata;
   logic                      commit_valid;
   logic [DATA_WIDTH-1:0]     commit_pc;
   logic                      wb_busy;
   logic [REG_ADDR_WIDTH-1:0] wb_rd;
   logic                      lsu_timeout;
   modport master (
      output in_valid, in_lsu_opt, in_exu_result, in_csr_result, in_rd, in_rd_wen, in_pc,
             lsu_rsp_valid, lsu_rdata,
      input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, wb_busy, wb_rd,
             lsu_timeout
   );
   modport slave (
      input  in_valid, in_lsu_opt, in_exu_result, in_csr_result, in_rd, in_rd_wen, in_pc,
             lsu_rsp_valid, lsu_rdata,
      output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, wb_busy, wb_rd,
             lsu_timeout
   );
endinterface

// File: rtl/ysyx_23060077_wb_ctrl.sv
// ysyx_23060077_wb_ctrl: retires one instruction at a time, waiting on the LSU for memory ops,
// and issues a single register-file write plus commit pulse per instruction.
module ysyx_23060077_wb_ctrl #(
   parameter int                       DATA_WIDTH     = 32,
   parameter int                       LSU_OPT_WIDTH  = 4,
   parameter int                       REG_ADDR_WIDTH = 5,
   parameter logic [LSU_OPT_WIDTH-1:0] LSU_OPT_NONE   = '0,
   parameter logic [LSU_OPT_WIDTH-1:0] LSU_OPT_SYS    = LSU_OPT_WIDTH'('hF),
   parameter int                       TIMEOUT        = 255
) (
   input logic                    clock,
   input logic                    reset,
   ysyx_23060077_wb_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_LSU, COMMIT} state_t;
   state_t                    r_state, w_next;
   logic [LSU_OPT_WIDTH-1:0]  r_opt;
   logic [DATA_WIDTH-1:0]     r_exu, r_csr, r_pc, r_rdata, w_result;
   logic [REG_ADDR_WIDTH-1:0] r_rd;
   logic                      r_rd_wen, r_timeout;
   logic [7:0]                r_cnt;
   logic                      w_accept, w_is_mem, w_expire, w_commit, w_busy;
   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_is_mem = (bus.in_lsu_opt != LSU_OPT_NONE) && (bus.in_lsu_opt != LSU_OPT_SYS);
   assign w_expire = r_cnt == 8'(TIMEOUT - 1);
   assign w_commit = r_state == COMMIT;
   assign w_busy   = r_state != IDLE;
   assign w_result = r_opt == LSU_OPT_NONE ? r_exu : r_opt == LSU_OPT_SYS ? r_csr : r_rdata;
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = w_is_mem ? WAIT_LSU : COMMIT;
      else if (r_state == COMMIT) w_next = IDLE;
      else if (r_state == WAIT_LSU && (bus.lsu_rsp_valid || w_expire)) w_next = COMMIT;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_opt     <= '0;
         r_exu     <= '0;
         r_csr     <= '0;
         r_pc      <= '0;
         r_rdata   <= '0;
         r_rd      <= '0;
         r_rd_wen  <= 1'b0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_opt    <= bus.in_lsu_opt;
            r_exu    <= bus.in_exu_result;
            r_csr    <= bus.in_csr_result;
            r_pc     <= bus.in_pc;
            r_rd     <= bus.in_rd;
            r_rd_wen <= bus.in_rd_wen;
            r_cnt    <= '0;
         end
         // a response in the expiry cycle takes priority over the watchdog
         if (r_state == WAIT_LSU) begin
            if (bus.lsu_rsp_valid) r_rdata <= bus.lsu_rdata;
            else if (w_expire) begin
               r_rdata   <= '0;
               r_timeout <= 1'b1;
            end else r_cnt <= r_cnt + 8'd1;
         end
      end
   end
   assign bus.in_ready     = !reset && r_state != WAIT_LSU;
   assign bus.commit_valid = w_commit;
   assign bus.commit_pc    = w_commit ? r_pc : '0;
   assign bus.rf_wen       = w_commit & r_rd_wen & (|r_rd);
   assign bus.rf_waddr     = w_commit ? r_rd : '0;
   assign bus.rf_wdata     = w_commit ? w_result : '0;
   assign bus.wb_busy      = w_busy;
   assign bus.wb_rd        = w_busy ? r_rd : '0;
   assign bus.lsu_timeout  = r_timeout;
endmodule
